axi_master_wr: RTL and testbench

//  AXI4 write master driven by axi_ctrl's write-side command interface (start/addr/len/data).
//  On each accepted start it issues one INCR burst (AW, then W beats, then B).
//  W data is streamed straight from the write FIFO's first-word-fall-through output.
//  wr_writing doubles as that FIFO's read enable and as axi_ctrl's address-advance strobe.

---
 rtl/axi_master_wr_if.sv | 49 ++++
 rtl/axi_master_wr.sv | 185 ++++++++++++++++++
 tb/tb_axi_master_wr.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/axi_master_wr_if.sv
// AXI4 write-channel bundle (AW, W, B) between axi_master_wr and the interconnect.
interface axi_master_wr_if #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) ();

  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/axi_master_wr.sv
// AXI4 write master: one INCR burst (AW, W beats streamed from a FWFT FIFO, B) per accepted wr_start.
// Optional: `define AXI_WR_RESP_CHK_EN adds wr_resp_err (sticky) and wr_err_cnt (saturating) outputs.
module axi_master_wr #(
  parameter int              ADDR_W = 30,
  parameter int              DATA_W = 64,
  parameter int              ID_W   = 4,
  parameter logic [ID_W-1:0] AXI_ID = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_start,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_len,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              wr_writing,
  output logic              wr_done,
`ifdef AXI_WR_RESP_CHK_EN
  output logic              wr_resp_err,
  output logic [7:0]        wr_err_cnt,
`endif
  axi_master_wr_if.master   m_axi
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_AW,
    S_W,
    S_B
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic              wr_ready_q, wr_ready_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              wr_done_q, wr_done_d;

  logic aw_hs;
  logic w_hs;
  logic wlast;

  assign aw_hs = awvalid_q & m_axi.awready;
  assign w_hs  = wvalid_q & m_axi.wready;
  assign wlast = wvalid_q & (beat_cnt_q == len_q);

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    beat_cnt_d = beat_cnt_q;
    wr_ready_d = wr_ready_q;
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    bready_d   = bready_q;
    wr_done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (wr_start) begin
          state_d    = S_LATCH;
          wr_ready_d = 1'b0;
        end
      end
      // Length arrives from axi_ctrl one cycle after start, so capture here rather than in IDLE.
      S_LATCH: begin
        addr_d  = wr_addr;
        len_d   = wr_len;
        state_d = S_AW;
      end
      // AWVALID rises one cycle into AW, so address and length are already stable on the bus.
      S_AW: begin
        awvalid_d = 1'b1;
        if (aw_hs) begin
          awvalid_d  = 1'b0;
          wvalid_d   = 1'b1;
          beat_cnt_d = '0;
          state_d    = S_W;
        end
      end
      S_W: begin
        if (w_hs) begin
          if (wlast) begin
            wvalid_d = 1'b0;
            bready_d = 1'b1;
            state_d  = S_B;
          end else begin
            beat_cnt_d = beat_cnt_q + 8'd1;
          end
        end
      end
      S_B: begin
        if (m_axi.bvalid) begin
          bready_d   = 1'b0;
          wr_done_d  = 1'b1;
          wr_ready_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      beat_cnt_q <= '0;
      wr_ready_q <= 1'b1;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      wr_done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples the pre-edge values of the others.
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      beat_cnt_q <= beat_cnt_d;
      wr_ready_q <= wr_ready_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      wr_done_q  <= wr_done_d;
    end
  end

`ifdef AXI_WR_RESP_CHK_EN
  logic       resp_err_q, resp_err_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    resp_err_d = resp_err_q;
    err_cnt_d  = err_cnt_q;
    if (state_q == S_B && m_axi.bvalid && m_axi.bresp != 2'b00) begin
      resp_err_d = 1'b1;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      resp_err_q <= resp_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign wr_resp_err = resp_err_q;
  assign wr_err_cnt  = err_cnt_q;
`endif

  // BID is never checked and BRESP only matters with the response checker built in.
  logic unused_b;
  assign unused_b = ^{m_axi.bid, m_axi.bresp};

  assign wr_ready   = wr_ready_q;
  assign wr_writing = w_hs;
  assign wr_done    = wr_done_q;

  assign m_axi.awid    = AXI_ID;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awlen   = len_q;
  assign m_axi.awsize  = 3'b011;
  assign m_axi.awburst = 2'b01;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = 4'b0010;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awqos   = 4'b0000;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wr_data;
  assign m_axi.wstrb   = '1;
  assign m_axi.wlast   = wlast;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;

endmodule

// File: tb/tb_axi_master_wr.sv
// Directed + randomized bench for axi_master_wr: behavioural requester/FIFO/slave with per-burst scoreboard.
module tb_axi_master_wr;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 64;
  localparam int ID_W   = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              wr_start;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              wr_writing;
  logic              wr_done;
`ifdef AXI_WR_RESP_CHK_EN
  logic              wr_resp_err;
  logic [7:0]        wr_err_cnt;
`endif

  axi_master_wr_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) m_axi ();

  axi_master_wr #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .AXI_ID(4'd0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_start   (wr_start),
    .wr_addr    (wr_addr),
    .wr_len     (wr_len),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .wr_writing (wr_writing),
    .wr_done    (wr_done),
`ifdef AXI_WR_RESP_CHK_EN
    .wr_resp_err(wr_resp_err),
    .wr_err_cnt (wr_err_cnt),
`endif
    .m_axi      (m_axi)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] fifo[$];
  logic [1:0] b_resp_val = 2'b00;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One burst from the requester's point of view. Called and returns just after a falling edge.
  // wmode: 0 = wready always 1, 1 = wready toggles each cycle, 2 = random wready.
  task automatic run_burst(input string name, input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                           input int aw_delay, input int wmode, input int b_delay,
                           input bit keep_start, input bit chk_lat, input int rst_beat);
    int beats = 0, wv_cycles = 0, stalls = 0, aw_cycles = 0, first_aw = -1;
    int done_cnt = 0, done_cyc = -1, b_pend = -1, cyc = 0;
    int bad_aw = 0, bad_w = 0, bad_order = 0;
    bit aw_done = 1'b0, finished = 1'b0, prev_awvalid = 1'b0;

    fifo.delete();
    for (int i = 0; i < int'(len) + 3; i++) fifo.push_back({$urandom, $urandom});
    wr_data       = fifo[0];
    m_axi.awready = (aw_delay == 0);
    m_axi.wready  = 1'b0;
    m_axi.bvalid  = 1'b0;
    m_axi.bresp   = 2'b00;
    m_axi.bid     = '0;
    wr_addr       = addr;
    if (wr_start) begin
      wr_len = len;
    end else begin
      // The requester's length lags start by one cycle; show a stale value first.
      wr_len   = ~len;
      wr_start = 1'b1;
    end

    while (!finished && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      wr_len  = len;
      if (!keep_start && !wr_ready) wr_start = 1'b0;
      wr_data = fifo[0];
      m_axi.awready = (aw_cycles >= aw_delay);
      case (wmode)
        0:       m_axi.wready = 1'b1;
        1:       m_axi.wready = cyc[0];
        default: m_axi.wready = 1'($urandom_range(0, 1));
      endcase
      m_axi.bvalid = (b_pend >= 0 && cyc >= b_pend);
      m_axi.bresp  = m_axi.bvalid ? b_resp_val : 2'b00;

      if (rst_beat >= 0 && beats == rst_beat && m_axi.wvalid) begin
        rst_n = 1'b0;
        #1;
        check({name, "/rst_awvalid"}, m_axi.awvalid, 1'b0);
        check({name, "/rst_wvalid"}, m_axi.wvalid, 1'b0);
        check({name, "/rst_wlast"}, m_axi.wlast, 1'b0);
        check({name, "/rst_bready"}, m_axi.bready, 1'b0);
        check({name, "/rst_writing"}, wr_writing, 1'b0);
        check({name, "/rst_ready"}, wr_ready, 1'b1);
        check({name, "/rst_awaddr"}, m_axi.awaddr, 0);
        check({name, "/rst_awlen"}, m_axi.awlen, 0);
        @(negedge clk);
        #1;
        check({name, "/rst_next_valids"}, {m_axi.awvalid, m_axi.wvalid, m_axi.bready, wr_done}, 4'b0000);
        check({name, "/rst_next_ready"}, wr_ready, 1'b1);
        rst_n        = 1'b1;
        wr_start     = 1'b0;
        m_axi.bvalid = 1'b0;
        return;
      end
      #1;

      if (m_axi.awvalid) begin
        if (first_aw < 0) first_aw = cyc;
        aw_cycles++;
        if (m_axi.awaddr !== addr || m_axi.awlen !== len) bad_aw++;
      end else if (prev_awvalid && !aw_done) begin
        bad_aw++;
      end
      if (m_axi.wvalid) begin
        wv_cycles++;
        if (!aw_done || beats > int'(len)) bad_order++;
        if (m_axi.wdata !== fifo[0]) bad_w++;
        if (m_axi.wlast !== (beats == int'(len))) bad_w++;
        if (!m_axi.wready) stalls++;
      end else if (m_axi.wlast !== 1'b0) begin
        bad_w++;
      end
      if (wr_writing !== (m_axi.wvalid & m_axi.wready)) bad_w++;
      if (m_axi.bready && beats != int'(len) + 1) bad_order++;
      if (m_axi.awvalid && m_axi.awready) aw_done = 1'b1;
      prev_awvalid = m_axi.awvalid;
      if (wr_writing) begin
        beats++;
        if (fifo.size() > 1) void'(fifo.pop_front());
        if (beats == int'(len) + 1) b_pend = cyc + 1 + b_delay;
      end
      if (m_axi.bvalid && m_axi.bready) b_pend = -1;
      if (wr_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        if (!wr_ready) bad_order++;
      end
      if (done_cyc >= 0 && (keep_start || cyc > done_cyc)) finished = 1'b1;
    end

    check({name, "/finished"}, finished, 1'b1);
    check({name, "/aw_stable"}, bad_aw, 0);
    check({name, "/aw_cycles"}, aw_cycles, aw_delay + 1);
    check({name, "/beats"}, beats, int'(len) + 1);
    check({name, "/wdata_wlast"}, bad_w, 0);
    check({name, "/order"}, bad_order, 0);
    check({name, "/wvalid_cycles"}, wv_cycles - stalls, int'(len) + 1);
    if (!keep_start) check({name, "/done_pulses"}, done_cnt, 1);
    if (chk_lat) begin
      check({name, "/aw_latency"}, first_aw, 3);
      check({name, "/done_latency"}, done_cyc, int'(len) + 6);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired before the summary line");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_start      = 1'b0;
    wr_addr       = '0;
    wr_len        = '0;
    wr_data       = '0;
    m_axi.awready = 1'b0;
    m_axi.wready  = 1'b0;
    m_axi.bvalid  = 1'b0;
    m_axi.bresp   = 2'b00;
    m_axi.bid     = '0;
    repeat (2) @(negedge clk);
    #1;

    check("reset/wr_ready", wr_ready, 1'b1);
    check("reset/valids", {m_axi.awvalid, m_axi.wvalid, m_axi.wlast, m_axi.bready}, 4'b0000);
    check("reset/writing_done", {wr_writing, wr_done}, 2'b00);
    check("reset/awaddr", m_axi.awaddr, 0);
    check("reset/awlen", m_axi.awlen, 0);
    check("const/awid", m_axi.awid, 0);
    check("const/awsize", m_axi.awsize, 3'b011);
    check("const/awburst", m_axi.awburst, 2'b01);
    check("const/awcache", m_axi.awcache, 4'b0010);
    check("const/lock_prot_qos", {m_axi.awlock, m_axi.awprot, m_axi.awqos}, 0);
    check("const/wstrb", m_axi.wstrb, 8'hFF);

    rst_n = 1'b1;
    @(negedge clk);
    #1;

    run_burst("t1_len7", 30'h100, 8'd7, 0, 0, 0, 1'b0, 1'b1, -1);
    run_burst("t2_len0", 30'h180, 8'd0, 0, 0, 0, 1'b0, 1'b1, -1);
    run_burst("t3_toggle", 30'h1000, 8'd15, 0, 1, 0, 1'b0, 1'b0, -1);
    run_burst("t4_awdelay", 30'h200, 8'd3, 5, 0, 0, 1'b0, 1'b0, -1);
    run_burst("t5_held_a", 30'h100, 8'd3, 0, 0, 0, 1'b1, 1'b1, -1);
    run_burst("t5_held_b", 30'h140, 8'd5, 0, 0, 0, 1'b0, 1'b1, -1);
    run_burst("t6_reset", 30'h300, 8'd7, 0, 0, 0, 1'b0, 1'b0, 2);
    run_burst("t6_after", 30'h340, 8'd2, 0, 0, 0, 1'b0, 1'b1, -1);
    run_burst("len255", 30'h8000, 8'd255, 0, 0, 0, 1'b0, 1'b1, -1);
    run_burst("bdelay", 30'h400, 8'd4, 1, 0, 3, 1'b0, 1'b0, -1);

    for (int k = 0; k < 6; k++) begin
      run_burst($sformatf("rnd%0d", k), ADDR_W'($urandom & 32'h3FFF_FFF8), 8'($urandom_range(0, 31)),
                int'($urandom_range(0, 3)), 2, int'($urandom_range(0, 3)), 1'b0, 1'b0, -1);
    end

`ifdef AXI_WR_RESP_CHK_EN
    check("resp/clean_flag", wr_resp_err, 1'b0);
    b_resp_val = 2'b10;
    run_burst("resp_slverr", 30'h500, 8'd1, 0, 0, 0, 1'b0, 1'b0, -1);
    b_resp_val = 2'b00;
    check("resp/err_flag", wr_resp_err, 1'b1);
    check("resp/err_cnt", wr_err_cnt, 8'd1);
    run_burst("resp_okay", 30'h540, 8'd1, 0, 0, 0, 1'b0, 1'b0, -1);
    check("resp/flag_sticky", wr_resp_err, 1'b1);
    check("resp/cnt_held", wr_err_cnt, 8'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
